bcd_calc_engine: RTL and testbench
==================================

BCD_CALC_ENGINE -- requirements
Module: bcd_calc_engine

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving operand width in BCD digits; the display holds 2*DIGITS digits.
REQ-002 SHALL derive localparam WB = ceil(log2(10^DIGITS)), the binary width of one operand (14 for DIGITS=4).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port key_valid, input, 1 bit: key_code is valid this cycle.
REQ-006 SHALL have port key_code, input, 5 bits: 0x0-0x9 digit, 0xA add, 0xB sub, 0xC mul, 0xD div, 0xE back, 0xF clear, 0x10-0x1F no-op.
REQ-007 SHALL have port key_ready, output, 1 bit: the block accepts a key; equals ~busy.
REQ-008 SHALL have port busy, output, 1 bit: an arithmetic operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when an operation ends.
REQ-010 SHALL have port disp_data, output, 8*DIGITS bits: BCD display; nibble 0 is the least-significant digit.
REQ-011 SHALL have port neg, output, 1 bit: the last SUB result is negative.
REQ-012 SHALL have port err, output, 1 bit: the last DIV had a zero divisor.

Function
REQ-013 SHALL accept a key only on a rising edge where key_valid and key_ready are both 1; keys offered while busy SHALL be dropped, not queued.
REQ-014 SHALL make every accepted key clear neg and err, except that the operation's own result sets them as below.
REQ-015 SHALL, on a digit key, shift disp_data left by one nibble and insert the key into nibble 0; latency 1 cycle; busy stays 0.
REQ-016 SHALL, on back, shift disp_data right one nibble with the top nibble set to 0; on clear, set disp_data to 0; each takes 1 cycle.
REQ-017 SHALL treat codes 0x10-0x1F as accepted no-ops.
REQ-018 SHALL, on an op key, take operand N1 from the low DIGITS digits and operand N2 from the high DIGITS digits.
REQ-019 SHALL implement the FSM IDLE -> LOAD (DIGITS cycles, both operands converted by Horner x10+digit, one digit per cycle) -> EXEC -> CONV -> DONE (1 cycle: write disp_data, pulse done) -> IDLE.
REQ-020 SHALL set busy from the cycle after op acceptance until DONE, inclusive.
REQ-021 SHALL compute ADD as R = N1+N2, in 1 EXEC cycle.
REQ-022 SHALL compute SUB as R = |N1-N2| with neg=1 iff N1<N2, in 1 EXEC cycle.
REQ-023 SHALL compute MUL as R = N1*N2, in 1 EXEC cycle.
REQ-024 SHALL display ADD, SUB and MUL results as the full 2*DIGITS-digit decimal R, so the high half is R/10^DIGITS and the low half is R mod 10^DIGITS.
REQ-025 SHALL convert ADD, SUB and MUL results by double-dabble over a 2*WB-bit value in 2*WB CONV cycles.
REQ-026 SHALL compute DIV as restoring division, 1 bit per cycle, WB EXEC cycles; the high half shows N2/N1 and the low half shows N2 mod N1.
REQ-027 SHALL convert the DIV quotient and remainder with double-dabble in split mode (two independent DIGITS-digit halves, no carry between them) in WB cycles.
REQ-028 SHALL give total busy duration DIGITS+2*WB+2 cycles for ADD, SUB and MUL, and DIGITS+2*WB+1 cycles for DIV.
REQ-029 SHALL, when DIV has N1=0 at the end of LOAD, go directly to DONE, set err=1 and leave disp_data unchanged; busy lasts DIGITS+1 cycles.
REQ-030 SHALL never overflow, since all results fit in 2*DIGITS digits, so no overflow flag exists.

Reset
REQ-031 SHALL, when RST_N is low, immediately force the FSM to IDLE and set disp_data=0, busy=0, done=0, neg=0, err=0 and key_ready=1, including mid-operation.
REQ-032 SHALL accept keys from the first rising edge after RST_N is released.

Structure
REQ-033 SHALL place key-code constants, the FSM state encoding and the WB width function in shared package bcd_calc_pkg.
REQ-034 SHALL implement the double-dabble converter as sub-module bcd_dd_conv, parametrised by DIGITS, with a split-mode input.

Verification (DIGITS=4)
REQ-035 SHALL cover: keys 1,2,3,4 -> disp_data=0x00001234, busy never asserted, then back -> 0x00000123.
REQ-036 SHALL cover: disp 0x00120034, key A -> busy for 34 cycles, done pulse, disp_data=0x00000046.
REQ-037 SHALL cover: disp 0x99999999, key C -> disp_data=0x99980001, neg=0.
REQ-038 SHALL cover: disp 0x00500020, key B -> disp_data=0x00000030, neg=1; the next digit key clears neg.
REQ-039 SHALL cover: disp 0x01000007, key D -> 33 busy cycles, disp_data=0x00140002; then disp 0x01000000, key D -> err=1, disp unchanged, 5 busy cycles.
REQ-040 SHALL cover: RST_N pulsed low during CONV -> disp_data=0 and busy=0 without waiting for CLK; a key offered while busy is dropped and has no effect.

Source files
------------

// File: rtl/bcd_calc_pkg.sv
// Shared definitions for the BCD calculator engine.
// Contents: key-code constants, the controller state encoding and the
// function giving the binary width of a DIGITS-digit decimal operand.
package bcd_calc_pkg;

  localparam logic [4:0] KEY_ADD   = 5'h0A;
  localparam logic [4:0] KEY_SUB   = 5'h0B;
  localparam logic [4:0] KEY_MUL   = 5'h0C;
  localparam logic [4:0] KEY_DIV   = 5'h0D;
  localparam logic [4:0] KEY_BACK  = 5'h0E;
  localparam logic [4:0] KEY_CLEAR = 5'h0F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_CONV,
    ST_DONE
  } state_t;

  // Smallest width able to hold 10^digits - 1, i.e. ceil(log2(10^digits)).
  function automatic int calc_wb(input int digits);
    longint pow10;
    int     w;
    pow10 = 1;
    for (int i = 0; i < digits; i++) pow10 = pow10 * 10;
    w = 0;
    while ((longint'(1) << w) < pow10) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_calc_engine_conv.sv
// Sequential double-dabble binary-to-BCD converter.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load_i     : capture bin_i and split_i, clear the BCD accumulator
//   step_i     : perform one add-3/shift iteration
//   split_i    : 1 = convert the two WB-bit halves into two independent
//                DIGITS-digit halves, 0 = convert one 2*WB-bit value
//   bin_i      : binary value (split: {high half, low half})
//   bcd_o      : 2*DIGITS BCD digits, digit 0 in the low nibble
module bcd_dd_conv
  import bcd_calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_i,
  input  logic                          step_i,
  input  logic                          split_i,
  input  logic [2*calc_wb(DIGITS)-1:0]  bin_i,
  output logic [8*DIGITS-1:0]           bcd_o
);

  localparam int WB = calc_wb(DIGITS);

  logic [2*WB-1:0]     bin_q;
  logic [8*DIGITS-1:0] bcd_q, bcd_d;
  logic [8*DIGITS-2:0] adj;
  logic                split_q;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Add-3 correction of every digit, then shift in the next binary bit.
  // The top digit never exceeds 4 before the shift because every result
  // fits in the display, so its adjusted MSB is never needed.
  // In split mode only WB steps run, so plain left shifts of bin_q never
  // move a low-half bit up to the high-half read position.
  always_comb begin
    adj = '0;
    for (int i = 0; i < 2*DIGITS-1; i++) adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
    adj[8*DIGITS-2 -: 3] = 3'(add3(bcd_q[8*DIGITS-1 -: 4]));
    if (split_q) begin
      bcd_d = {adj[8*DIGITS-2:4*DIGITS], bin_q[2*WB-1],
               adj[4*DIGITS-2:0],        bin_q[WB-1]};
    end else begin
      bcd_d = {adj[8*DIGITS-2:0], bin_q[2*WB-1]};
    end
  end

  // Converter state: load clears the accumulator, each step shifts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      split_q <= 1'b0;
    end else if (load_i) begin
      bin_q   <= bin_i;
      bcd_q   <= '0;
      split_q <= split_i;
    end else if (step_i) begin
      bin_q   <= bin_q << 1;
      bcd_q   <= bcd_d;
    end
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/bcd_calc_engine.sv
// Keypad-driven BCD calculator engine.
// Digit keys shift into a 2*DIGITS-digit BCD display. An operation key
// takes N1 from the low DIGITS digits and N2 from the high DIGITS digits,
// computes ADD/SUB/MUL/DIV in binary and converts the result back to BCD.
// Ports:
//   CLK, RST_N  : clock (rising edge) and asynchronous active-low reset
//   key_valid   : key_code is offered this cycle
//   key_code    : 0-9 digit, A add, B sub, C mul, D div, E back, F clear,
//                 10-1F no-op
//   key_ready   : a key is accepted this cycle (not busy)
//   busy        : an arithmetic operation is running
//   done        : single-cycle pulse in the last cycle of an operation
//   disp_data   : BCD display, nibble 0 least significant
//   neg, err    : last SUB was negative / last DIV had a zero divisor
module bcd_calc_engine
  import bcd_calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                key_valid,
  input  logic [4:0]          key_code,
  output logic                key_ready,
  output logic                busy,
  output logic                done,
  output logic [8*DIGITS-1:0] disp_data,
  output logic                neg,
  output logic                err
);

  localparam int WB = calc_wb(DIGITS);
  localparam int CW = $clog2(2*WB + 1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(DIGITS - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(WB - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(2*WB - 1);

  state_t              state_q, state_d;
  logic [4:0]          opCode_q;
  logic [WB-1:0]       n1_q, n2_q, divRem_q;
  logic [CW-1:0]       cnt_q;
  logic [8*DIGITS-1:0] disp_q;
  logic                neg_q, err_q;

  logic                accept, isDigit, isOp;
  logic [3:0]          loDigit, hiDigit;
  logic [WB-1:0]       n1Next, n2Next, quoNext, remNext;
  logic [WB:0]         divShift;
  logic [2*WB-1:0]     result;
  logic                convLoad, convStep, convSplit;
  logic [8*DIGITS-1:0] convBcd;

  assign accept  = key_valid && key_ready;
  assign isDigit = (key_code <= 5'd9);
  assign isOp    = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);

  // Horner load: most significant digit first, one digit of each operand
  // per LOAD cycle.
  always_comb begin
    loDigit = '0;
    hiDigit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CW'(DIGITS - 1 - i)) begin
        loDigit = disp_q[4*i +: 4];
        hiDigit = disp_q[4*(DIGITS+i) +: 4];
      end
    end
    n1Next = n1_q * WB'(10) + {{(WB-4){1'b0}}, loDigit};
    n2Next = n2_q * WB'(10) + {{(WB-4){1'b0}}, hiDigit};
  end

  // One restoring-division step: N2 shifts out into the remainder and the
  // quotient bits shift into N2's place.
  always_comb begin
    divShift = {divRem_q, n2_q[WB-1]};
    if (divShift >= {1'b0, n1_q}) begin
      remNext = WB'(divShift - {1'b0, n1_q});
      quoNext = {n2_q[WB-2:0], 1'b1};
    end else begin
      remNext = divShift[WB-1:0];
      quoNext = {n2_q[WB-2:0], 1'b0};
    end
  end

  // Binary value handed to the converter when EXEC ends. DIV uses the
  // final step's next values since they are loaded on the same edge.
  always_comb begin
    result = '0;
    case (opCode_q)
      KEY_ADD: result = {{WB{1'b0}}, n1_q} + {{WB{1'b0}}, n2_q};
      KEY_SUB: result = (n1_q >= n2_q) ? {{WB{1'b0}}, n1_q - n2_q}
                                       : {{WB{1'b0}}, n2_q - n1_q};
      KEY_MUL: result = {{WB{1'b0}}, n1_q} * {{WB{1'b0}}, n2_q};
      KEY_DIV: result = {quoNext, remNext};
      default: result = '0;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. A zero divisor skips EXEC and CONV entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && isOp) state_d = ST_LOAD;
      ST_LOAD: if (cnt_q == LOAD_LAST)
                 state_d = (opCode_q == KEY_DIV && n1Next == '0) ? ST_DONE : ST_EXEC;
      ST_EXEC: if (opCode_q != KEY_DIV || cnt_q == DIV_LAST) state_d = ST_CONV;
      ST_CONV: if (cnt_q == ((opCode_q == KEY_DIV) ? DIV_LAST : FULL_LAST))
                 state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and converter controls decoded from the current state.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    key_ready = (state_q == ST_IDLE);
    done      = (state_q == ST_DONE);
    convLoad  = (state_q == ST_EXEC) && (state_d == ST_CONV);
    convStep  = (state_q == ST_CONV);
    convSplit = (opCode_q == KEY_DIV);
  end

  // Datapath: key handling in IDLE, operand load, division steps and the
  // final display/flag write in DONE. The cycle counter restarts on every
  // state change.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q    <= '0;
      opCode_q <= '0;
      n1_q     <= '0;
      n2_q     <= '0;
      divRem_q <= '0;
      disp_q   <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ST_IDLE || state_d != state_q) cnt_q <= '0;
      else                                          cnt_q <= cnt_q + CW'(1);
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            neg_q <= 1'b0;
            err_q <= 1'b0;
            if (isDigit) begin
              disp_q <= {disp_q[8*DIGITS-5:0], key_code[3:0]};
            end else if (key_code == KEY_BACK) begin
              disp_q <= {4'h0, disp_q[8*DIGITS-1:4]};
            end else if (key_code == KEY_CLEAR) begin
              disp_q <= '0;
            end else if (isOp) begin
              opCode_q <= key_code;
              n1_q     <= '0;
              n2_q     <= '0;
              divRem_q <= '0;
            end
          end
        end
        ST_LOAD: begin
          n1_q <= n1Next;
          n2_q <= n2Next;
        end
        ST_EXEC: begin
          if (opCode_q == KEY_DIV) begin
            n2_q     <= quoNext;
            divRem_q <= remNext;
          end
        end
        ST_DONE: begin
          if (opCode_q == KEY_DIV && n1_q == '0) begin
            err_q <= 1'b1;
          end else begin
            disp_q <= convBcd;
            neg_q  <= (opCode_q == KEY_SUB) && (n1_q < n2_q);
          end
        end
        default: ;
      endcase
    end
  end

  bcd_dd_conv #(.DIGITS(DIGITS)) u_conv (
    .clk     (CLK),
    .rst_n   (RST_N),
    .load_i  (convLoad),
    .step_i  (convStep),
    .split_i (convSplit),
    .bin_i   (result),
    .bcd_o   (convBcd)
  );

  assign disp_data = disp_q;
  assign neg       = neg_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_calc_engine.sv
// Directed bench for bcd_calc_engine (DIGITS = 4). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_bcd_calc_engine;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_ready;
  logic        busy;
  logic        done;
  logic [31:0] disp_data;
  logic        neg;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  bcd_calc_engine #(.DIGITS(4)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done),
    .disp_data (disp_data),
    .neg       (neg),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  // Offer one key for exactly one rising edge.
  task automatic press(input logic [4:0] c);
    @(negedge CLK);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge CLK);
    key_valid = 1'b0;
    key_code  = 5'h10;
  endtask

  // Clear the display and type an 8-digit BCD value, most significant first.
  task automatic enter(input logic [31:0] v);
    press(5'h0F);
    for (int i = 7; i >= 0; i--) press({1'b0, v[4*i +: 4]});
  endtask

  // Press an operation key and count busy cycles and done pulses.
  task automatic run_op(input logic [4:0] c, output int cycles, output int dones);
    press(c);
    cycles = 0;
    dones  = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      if (done === 1'b1) dones++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0; key_valid = 1'b0; key_code = 5'h10;
    #12;
    vectors++; if (disp_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_disp: got %h want %h", disp_data, 32'h0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (key_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 1", key_ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    vectors++; if ({neg, err} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_flags: got %b want 00", {neg, err}); end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_digits;
    press(5'h0F);
    for (int k = 1; k <= 4; k++) begin
      press(5'(k));
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL digit_busy: got %b want 0", busy); end
    end
    vectors++; if (disp_data !== 32'h00001234) begin miscompares++; $display("[TB] FAIL digits_disp: got %h want %h", disp_data, 32'h00001234); end
    press(5'h0E);
    vectors++; if (disp_data !== 32'h00000123) begin miscompares++; $display("[TB] FAIL back_disp: got %h want %h", disp_data, 32'h00000123); end
  endtask

  task automatic test_add;
    int cyc, dn;
    enter(32'h00120034);
    run_op(5'h0A, cyc, dn);
    vectors++; if (cyc !== 34) begin miscompares++; $display("[TB] FAIL add_busy_cycles: got %0d want 34", cyc); end
    vectors++; if (dn !== 1) begin miscompares++; $display("[TB] FAIL add_done_pulses: got %0d want 1", dn); end
    vectors++; if (disp_data !== 32'h00000046) begin miscompares++; $display("[TB] FAIL add_disp: got %h want %h", disp_data, 32'h00000046); end
    vectors++; if (key_ready !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL add_idle: ready %b done %b want 1 0", key_ready, done); end
    enter(32'h99999999);
    run_op(5'h0A, cyc, dn);
    vectors++; if (disp_data !== 32'h00019998) begin miscompares++; $display("[TB] FAIL add_max_disp: got %h want %h", disp_data, 32'h00019998); end
  endtask

  task automatic test_mul;
    int cyc, dn;
    enter(32'h99999999);
    run_op(5'h0C, cyc, dn);
    vectors++; if (cyc !== 34) begin miscompares++; $display("[TB] FAIL mul_busy_cycles: got %0d want 34", cyc); end
    vectors++; if (disp_data !== 32'h99980001) begin miscompares++; $display("[TB] FAIL mul_disp: got %h want %h", disp_data, 32'h99980001); end
    vectors++; if (neg !== 1'b0) begin miscompares++; $display("[TB] FAIL mul_neg: got %b want 0", neg); end
  endtask

  task automatic test_sub;
    int cyc, dn;
    enter(32'h00500020);
    run_op(5'h0B, cyc, dn);
    vectors++; if (cyc !== 34) begin miscompares++; $display("[TB] FAIL sub_busy_cycles: got %0d want 34", cyc); end
    vectors++; if (disp_data !== 32'h00000030) begin miscompares++; $display("[TB] FAIL sub_neg_disp: got %h want %h", disp_data, 32'h00000030); end
    vectors++; if (neg !== 1'b1) begin miscompares++; $display("[TB] FAIL sub_neg_flag: got %b want 1", neg); end
    press(5'h05);
    vectors++; if (neg !== 1'b0) begin miscompares++; $display("[TB] FAIL sub_neg_clear: got %b want 0", neg); end
    vectors++; if (disp_data !== 32'h00000305) begin miscompares++; $display("[TB] FAIL sub_digit_disp: got %h want %h", disp_data, 32'h00000305); end
    enter(32'h00200050);
    run_op(5'h0B, cyc, dn);
    vectors++; if (disp_data !== 32'h00000030 || neg !== 1'b0) begin miscompares++; $display("[TB] FAIL sub_pos: got %h neg %b want 00000030 neg 0", disp_data, neg); end
  endtask

  task automatic test_div;
    int cyc, dn;
    enter(32'h01000007);
    run_op(5'h0D, cyc, dn);
    vectors++; if (cyc !== 33) begin miscompares++; $display("[TB] FAIL div_busy_cycles: got %0d want 33", cyc); end
    vectors++; if (dn !== 1) begin miscompares++; $display("[TB] FAIL div_done_pulses: got %0d want 1", dn); end
    vectors++; if (disp_data !== 32'h00140002) begin miscompares++; $display("[TB] FAIL div_disp: got %h want %h", disp_data, 32'h00140002); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL div_err: got %b want 0", err); end
    enter(32'h00030007);
    run_op(5'h0D, cyc, dn);
    vectors++; if (disp_data !== 32'h00000003) begin miscompares++; $display("[TB] FAIL div_small_disp: got %h want %h", disp_data, 32'h00000003); end
    enter(32'h01000000);
    run_op(5'h0D, cyc, dn);
    vectors++; if (cyc !== 5) begin miscompares++; $display("[TB] FAIL div0_busy_cycles: got %0d want 5", cyc); end
    vectors++; if (dn !== 1) begin miscompares++; $display("[TB] FAIL div0_done_pulses: got %0d want 1", dn); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL div0_err: got %b want 1", err); end
    vectors++; if (disp_data !== 32'h01000000) begin miscompares++; $display("[TB] FAIL div0_disp: got %h want %h", disp_data, 32'h01000000); end
    press(5'h13);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL noop_err_clear: got %b want 0", err); end
    vectors++; if (disp_data !== 32'h01000000) begin miscompares++; $display("[TB] FAIL noop_disp: got %h want %h", disp_data, 32'h01000000); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    enter(32'h00000012);
    press(5'h0A);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      key_valid = (cyc == 10);
      key_code  = 5'h07;
      @(negedge CLK);
    end
    key_valid = 1'b0;
    vectors++; if (cyc !== 34) begin miscompares++; $display("[TB] FAIL drop_busy_cycles: got %0d want 34", cyc); end
    vectors++; if (disp_data !== 32'h00000012) begin miscompares++; $display("[TB] FAIL drop_disp: got %h want %h", disp_data, 32'h00000012); end
  endtask

  task automatic test_reset_mid;
    enter(32'h00120034);
    press(5'h0A);
    repeat (10) @(negedge CLK);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_busy_before: got %b want 1", busy); end
    #2 RST_N = 1'b0;
    #1;
    vectors++; if (disp_data !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_reset_disp: got %h want %h", disp_data, 32'h0); end
    vectors++; if (busy !== 1'b0 || key_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_reset_busy: busy %b ready %b want 0 1", busy, key_ready); end
    @(negedge CLK);
    RST_N     = 1'b1;
    key_valid = 1'b1;
    key_code  = 5'h09;
    @(negedge CLK);
    key_valid = 1'b0;
    vectors++; if (disp_data !== 32'h00000009) begin miscompares++; $display("[TB] FAIL first_key_after_reset: got %h want %h", disp_data, 32'h00000009); end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, miscompares so far %0d", miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_digits();
    test_add();
    test_mul();
    test_sub();
    test_div();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
